// File: rtl/sdram_write_master.sv
// sdram_write_master: Avalon-MM write master draining a show-ahead user FIFO into SDRAM.
module sdram_write_master #(
  parameter int DATAWIDTH       = 16,
  parameter int BYTEENABLEWIDTH = 2,
  parameter int ADDRESSWIDTH    = 32,
  parameter int FIFODEPTH       = 32,
  parameter int FIFODEPTH_LOG2  = 5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0]    control_write_base,
  input  logic [ADDRESSWIDTH-1:0]    control_write_length,
  input  logic                       control_go,
  output logic                       control_done,
  input  logic                       user_write_buffer,
  input  logic [DATAWIDTH-1:0]       user_buffer_data,
  output logic                       user_buffer_full,
  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_write,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  output logic [DATAWIDTH-1:0]       master_writedata,
  input  logic                       master_waitrequest
);
  typedef enum logic {IDLE, WRITE} state_t;
  localparam logic [ADDRESSWIDTH-1:0]   STEP     = ADDRESSWIDTH'(BYTEENABLEWIDTH);
  localparam logic [ADDRESSWIDTH-1:0]   LEN_MASK = ~(STEP - ADDRESSWIDTH'(1));
  localparam logic [FIFODEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [FIFODEPTH_LOG2:0]   CNT_FULL = (FIFODEPTH_LOG2+1)'(FIFODEPTH);
  localparam logic [FIFODEPTH_LOG2-1:0] PTR_ONE  = 1;
  state_t state, state_next;
  logic [DATAWIDTH-1:0] mem [FIFODEPTH];
  logic [FIFODEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFODEPTH_LOG2:0] count, count_next;
  logic [ADDRESSWIDTH-1:0] address, remaining, len_rounded;
  logic fixed, empty, push, pop, start, last;
  assign len_rounded       = control_write_length & LEN_MASK;
  assign start             = (state == IDLE) && control_go && (len_rounded != '0);
  assign empty             = (count == '0);
  assign push              = user_write_buffer & ~user_buffer_full;
  assign pop               = master_write & ~master_waitrequest;
  assign last              = pop && (remaining == STEP);
  assign master_address    = address;
  assign master_byteenable = '1;
  assign master_writedata  = mem[rd_ptr];
  assign count_next = (push & ~pop) ? count + CNT_ONE :
                      (~push & pop) ? count - CNT_ONE : count;
  always_comb begin
    state_next   = start ? WRITE : last ? IDLE : state;
    control_done = (state == IDLE);
    master_write = (state == WRITE) && !empty;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address          <= '0;
      remaining        <= '0;
      fixed            <= 1'b0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      user_buffer_full <= 1'b0;
    end else begin
      count            <= count_next;
      user_buffer_full <= (count_next == CNT_FULL);
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (start) begin
        address   <= control_write_base;
        remaining <= len_rounded;
        fixed     <= control_fixed_location;
      end else if (pop) begin
        remaining <= remaining - STEP;
        if (!fixed) address <= address + STEP;
      end
    end
  end
  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= user_buffer_data;
  end
endmodule

// File: tb/tb_sdram_write_master.sv
// tb_sdram_write_master: directed scenario tests for sdram_write_master.
module tb_sdram_write_master;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic control_fixed_location = 1'b0;
  logic [31:0] control_write_base = '0;
  logic [31:0] control_write_length = '0;
  logic control_go = 1'b0;
  logic control_done;
  logic user_write_buffer = 1'b0;
  logic [15:0] user_buffer_data = '0;
  logic user_buffer_full;
  logic [31:0] master_address;
  logic master_write;
  logic [1:0] master_byteenable;
  logic [15:0] master_writedata;
  logic master_waitrequest = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] got_addr[$];
  logic [15:0] got_data[$];
  logic [15:0] pend[$];

  sdram_write_master dut (
    .clk(clk), .reset_n(reset_n),
    .control_fixed_location(control_fixed_location),
    .control_write_base(control_write_base),
    .control_write_length(control_write_length),
    .control_go(control_go), .control_done(control_done),
    .user_write_buffer(user_write_buffer), .user_buffer_data(user_buffer_data),
    .user_buffer_full(user_buffer_full),
    .master_address(master_address), .master_write(master_write),
    .master_byteenable(master_byteenable), .master_writedata(master_writedata),
    .master_waitrequest(master_waitrequest)
  );

  always #5 clk = ~clk;

  // Inputs change just after a falling edge; outputs are sampled 1 ns later.
  task automatic push_word(input logic [15:0] d);
    user_write_buffer = 1'b1;
    user_buffer_data = d;
    @(negedge clk);
    user_write_buffer = 1'b0;
  endtask

  task automatic go(input logic [31:0] base, input logic [31:0] len, input logic fx);
    control_write_base = base;
    control_write_length = len;
    control_fixed_location = fx;
    control_go = 1'b1;
    @(negedge clk);
    control_go = 1'b0;
  endtask

  // Steps until done, logging accepted writes; ws/wl stall window, pe push period for pend.
  task automatic collect(input int ws, input int wl, input int pe,
                         output int cyc, output int stalled, output int starved);
    got_addr.delete();
    got_data.delete();
    stalled = 0;
    starved = 0;
    cyc = 200;
    for (int i = 0; i < 200; i++) begin
      master_waitrequest = (i >= ws) && (i < ws + wl);
      if (pend.size() > 0 && pe > 0 && i % pe == 0) begin
        user_write_buffer = 1'b1;
        user_buffer_data = pend.pop_front();
      end else user_write_buffer = 1'b0;
      #1;
      if (control_done) begin
        cyc = i;
        break;
      end
      if (master_write && !master_waitrequest) begin
        got_addr.push_back(master_address);
        got_data.push_back(master_writedata);
      end
      if (master_write && master_waitrequest && master_address == 32'h102 && master_writedata == 16'h0022)
        stalled++;
      if (!master_write) starved++;
      @(negedge clk);
    end
    user_write_buffer = 1'b0;
    master_waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (control_done !== 1'b1) begin n_fail++; $display("FAIL reset_done got %b exp 1", control_done); end
    n_cmp++; if (master_write !== 1'b0) begin n_fail++; $display("FAIL reset_write got %b exp 0", master_write); end
    n_cmp++; if (user_buffer_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", user_buffer_full); end
    n_cmp++; if (master_address !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", master_address); end
    n_cmp++; if (master_byteenable !== 2'b11) begin n_fail++; $display("FAIL byteenable got %b exp 11", master_byteenable); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc, st, sv;
    for (int k = 1; k <= 4; k++) push_word(16'(k * 16'h11));
    go(32'h100, 32'd8, 1'b0);
    #1;
    n_cmp++; if (control_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_fall got %b exp 0", control_done); end
    collect(999, 0, 0, cyc, st, sv);
    n_cmp++; if (cyc !== 4) begin n_fail++; $display("FAIL basic_cycles got %0d exp 4", cyc); end
    n_cmp++; if (got_addr.size() !== 4) begin n_fail++; $display("FAIL basic_count got %0d exp 4", got_addr.size()); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (got_addr[k] !== 32'h100 + 32'(2 * k) || got_data[k] !== 16'(16'h11 * (k + 1))) begin
        n_fail++;
        $display("FAIL basic_write%0d got %h/%h exp %h/%h", k, got_addr[k], got_data[k], 32'h100 + 32'(2 * k), 16'(16'h11 * (k + 1)));
      end
    end
  endtask

  task automatic test_wait_states();
    int cyc, st, sv;
    for (int k = 1; k <= 4; k++) push_word(16'(k * 16'h11));
    go(32'h100, 32'd8, 1'b0);
    collect(1, 3, 0, cyc, st, sv);
    n_cmp++; if (st !== 3) begin n_fail++; $display("FAIL wait_held got %0d exp 3", st); end
    n_cmp++; if (cyc !== 7) begin n_fail++; $display("FAIL wait_cycles got %0d exp 7", cyc); end
    n_cmp++; if (got_addr.size() !== 4) begin n_fail++; $display("FAIL wait_count got %0d exp 4", got_addr.size()); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (got_addr[k] !== 32'h100 + 32'(2 * k) || got_data[k] !== 16'(16'h11 * (k + 1))) begin
        n_fail++;
        $display("FAIL wait_write%0d got %h/%h", k, got_addr[k], got_data[k]);
      end
    end
  endtask

  task automatic test_fixed_starve();
    int cyc, st, sv;
    pend = '{16'h00A1, 16'h00A2, 16'h00A3};
    go(32'h40, 32'd6, 1'b1);
    collect(999, 0, 5, cyc, st, sv);
    n_cmp++; if (cyc !== 12) begin n_fail++; $display("FAIL fixed_cycles got %0d exp 12", cyc); end
    n_cmp++; if (sv !== 9) begin n_fail++; $display("FAIL fixed_starved got %0d exp 9", sv); end
    n_cmp++; if (got_addr.size() !== 3) begin n_fail++; $display("FAIL fixed_count got %0d exp 3", got_addr.size()); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (got_addr[k] !== 32'h40 || got_data[k] !== 16'h00A1 + 16'(k)) begin
        n_fail++;
        $display("FAIL fixed_write%0d got %h/%h exp 00000040/%h", k, got_addr[k], got_data[k], 16'h00A1 + 16'(k));
      end
    end
  endtask

  task automatic test_fifo_full();
    int cyc, st, sv;
    for (int k = 0; k < 33; k++) begin
      push_word(16'hA000 + 16'(k));
      #1;
      if (k == 30) begin
        n_cmp++; if (user_buffer_full !== 1'b0) begin n_fail++; $display("FAIL full_early got %b exp 0", user_buffer_full); end
      end
      if (k == 31) begin
        n_cmp++; if (user_buffer_full !== 1'b1) begin n_fail++; $display("FAIL full_32 got %b exp 1", user_buffer_full); end
      end
      @(negedge clk);
    end
    go(32'h1000, 32'd64, 1'b0);
    collect(999, 0, 0, cyc, st, sv);
    n_cmp++; if (got_addr.size() !== 32) begin n_fail++; $display("FAIL full_count got %0d exp 32", got_addr.size()); end
    for (int k = 0; k < 32; k++) begin
      n_cmp++;
      if (got_data[k] !== 16'hA000 + 16'(k) || got_addr[k] !== 32'h1000 + 32'(2 * k)) begin
        n_fail++;
        $display("FAIL full_write%0d got %h/%h", k, got_addr[k], got_data[k]);
      end
    end
    #1;
    n_cmp++; if (user_buffer_full !== 1'b0) begin n_fail++; $display("FAIL full_drained got %b exp 0", user_buffer_full); end
    n_cmp++; if (master_write !== 1'b0) begin n_fail++; $display("FAIL full_leftover got %b exp 0", master_write); end
    @(negedge clk);
  endtask

  task automatic test_length_edges();
    int cyc, st, sv;
    push_word(16'h0B01);
    push_word(16'h0B02);
    push_word(16'h0B03);
    go(32'h200, 32'd0, 1'b0);
    collect(999, 0, 0, cyc, st, sv);
    n_cmp++; if (cyc !== 0 || got_addr.size() !== 0) begin n_fail++; $display("FAIL len0 got cyc %0d writes %0d exp 0/0", cyc, got_addr.size()); end
    go(32'h200, 32'd1, 1'b0);
    collect(999, 0, 0, cyc, st, sv);
    n_cmp++; if (cyc !== 0 || got_addr.size() !== 0) begin n_fail++; $display("FAIL len1 got cyc %0d writes %0d exp 0/0", cyc, got_addr.size()); end
    go(32'h200, 32'd5, 1'b0);
    collect(999, 0, 0, cyc, st, sv);
    n_cmp++; if (got_addr.size() !== 2) begin n_fail++; $display("FAIL len5_count got %0d exp 2", got_addr.size()); end
    n_cmp++;
    if (got_addr[0] !== 32'h200 || got_data[0] !== 16'h0B01 || got_addr[1] !== 32'h202 || got_data[1] !== 16'h0B02) begin
      n_fail++;
      $display("FAIL len5_writes got %h/%h %h/%h", got_addr[0], got_data[0], got_addr[1], got_data[1]);
    end
    go(32'h300, 32'd2, 1'b0);
    collect(999, 0, 0, cyc, st, sv);
    n_cmp++;
    if (got_addr.size() !== 1 || got_addr[0] !== 32'h300 || got_data[0] !== 16'h0B03) begin
      n_fail++;
      $display("FAIL leftover got n=%0d %h/%h exp 1 00000300/0b03", got_addr.size(), got_addr[0], got_data[0]);
    end
  endtask

  task automatic test_wrap();
    int cyc, st, sv;
    push_word(16'h0C01);
    push_word(16'h0C02);
    go(32'hFFFF_FFFE, 32'd4, 1'b0);
    collect(999, 0, 0, cyc, st, sv);
    n_cmp++;
    if (got_addr.size() !== 2 || got_addr[0] !== 32'hFFFF_FFFE || got_addr[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap got n=%0d %h %h exp fffffffe 00000000", got_addr.size(), got_addr[0], got_addr[1]);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, st, sv;
    for (int k = 1; k <= 4; k++) push_word(16'h0D00 + 16'(k));
    go(32'h500, 32'd8, 1'b0);
    #1;
    n_cmp++; if (master_write !== 1'b1 || master_address !== 32'h500) begin n_fail++; $display("FAIL mid_first got %b/%h exp 1/00000500", master_write, master_address); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++; if (master_write !== 1'b0 || control_done !== 1'b1) begin n_fail++; $display("FAIL mid_reset got write %b done %b exp 0/1", master_write, control_done); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    push_word(16'h0E01);
    push_word(16'h0E02);
    go(32'h600, 32'd4, 1'b0);
    collect(999, 0, 0, cyc, st, sv);
    n_cmp++;
    if (got_addr.size() !== 2 || got_addr[0] !== 32'h600 || got_data[0] !== 16'h0E01 || got_addr[1] !== 32'h602 || got_data[1] !== 16'h0E02) begin
      n_fail++;
      $display("FAIL mid_restart got n=%0d %h/%h %h/%h", got_addr.size(), got_addr[0], got_data[0], got_addr[1], got_data[1]);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_wait_states();
    test_fixed_starve();
    test_fifo_full();
    test_length_edges();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_write_master.md
Name: sdram_write_master

Overview:
- Avalon-MM write master that moves a user-pushed 16-bit data stream into SDRAM through the Qsys SDRAM controller.
- Write-direction counterpart of the existing read master: same control/user split (go/done control port, user buffer port).
- User logic queues words in an internal show-ahead FIFO, then issues go with base and length. The block drains the FIFO into sequential, or fixed, SDRAM addresses.

Parameters:
- DATAWIDTH, 16, data word width in bits; matches DRAM_DQ.
- BYTEENABLEWIDTH, 2, DATAWIDTH/8; also the address increment per word.
- ADDRESSWIDTH, 32, master address and length width.
- FIFODEPTH, 32, FIFO entries (power of 2).
- FIFODEPTH_LOG2, 5, log2(FIFODEPTH).

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset_n  in  1  asynchronous active-low reset
- control_fixed_location  in  1  1 = every write goes to write_base
- control_write_base  in  32  start byte address
- control_write_length  in  32  transfer length in bytes
- control_go  in  1  single-cycle start pulse
- control_done  out  1  high while idle / transfer complete
- user_write_buffer  in  1  push user_buffer_data into FIFO
- user_buffer_data  in  16  write data
- user_buffer_full  out  1  FIFO full
- master_address  out  32  Avalon byte address
- master_write  out  1  Avalon write request
- master_byteenable  out  2  constant all-ones
- master_writedata  out  16  FIFO head word
- master_waitrequest  in  1  Avalon waitrequest

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE; FIFO emptied.
  - Address and remaining-length registers = 0.
  - control_done = 1, master_write = 0, user_buffer_full = 0.
- States: IDLE, WRITE.
- IDLE:
  - control_done = 1; control_go is sampled only in this state.
  - On go with length >= BYTEENABLEWIDTH:
    - Latch base into the address register.
    - Latch length with its low log2(BYTEENABLEWIDTH) bits cleared; odd byte counts round down.
    - Latch fixed_location.
    - Next cycle: state = WRITE, control_done = 0.
  - On go with rounded length = 0: ignored; stays IDLE, done stays 1, no bus activity.
- WRITE:
  - master_write = 1 when FIFO not empty; otherwise 0 (starved, wait for data).
  - master_writedata = FIFO head, combinational show-ahead.
  - master_address = current address register.
  - Accept condition: master_write & ~master_waitrequest. On accept:
    - Pop FIFO.
    - Remaining -= BYTEENABLEWIDTH.
    - Address += BYTEENABLEWIDTH, unless fixed_location.
  - While waitrequest = 1: address, writedata and write are held stable; no pop.
  - When the accept makes remaining = 0: next cycle state = IDLE, control_done = 1, master_write = 0.
  - control_go in WRITE is ignored.
- FIFO:
  - Push when user_write_buffer & ~full; a push while full is dropped silently.
  - Pushes are allowed in any state, including before go. Words left over after done stay queued for the next transfer.
  - Simultaneous push and pop when not full: both occur and the count is unchanged.
  - user_buffer_full = (count == FIFODEPTH), registered from count.
- Address arithmetic: 32-bit wrap-around at 0xFFFFFFFE -> 0x00000000, no error.
- Latency: first master_write is asserted 1 cycle after go if the FIFO is non-empty. Throughput is 1 word/cycle with no wait states.

Test Plan:
- Basic write: push 0x0011, 0x0022, 0x0033, 0x0044; go with base 0x100, length 8, waitrequest 0 -> writes at 0x100/0x102/0x104/0x106 with those data on consecutive cycles. done falls the cycle after go and rises the cycle after the 4th accept.
- Wait states: as above but waitrequest = 1 for 3 cycles on the 2nd write -> address 0x102 and data 0x0022 held 4 cycles; no pop; total 4 accepts.
- Starvation and fixed location: fixed_location = 1, base 0x40, length 6, words pushed one every 5 cycles -> 3 writes all at 0x40. master_write is low while the FIFO is empty; done rises after the 3rd.
- FIFO full: 33 pushes with no go -> full = 1 after the 32nd. The 33rd is dropped: a later go with length 64 writes exactly the 32 pushed values in order.
- Length edge cases: go with length 0 or 1 -> done stays 1, no writes. Length 5 -> exactly 2 writes.
- Reset mid-operation: reset_n low during the 2nd of 4 writes -> master_write = 0 and done = 1 immediately, FIFO empty. After release, a new length-4 transfer starts at its new base.
